text_mode_renderer: RTL and testbench
=====================================

TEXT_MODE_RENDERER -- requirements
Module: text_mode_renderer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): H_PIXELS, 800, active pixels per line.
REQ-002 The block SHALL have parameter V_PIXELS, 600, active lines per frame.
REQ-003 The block SHALL have parameter COLS, 100, text columns (8-pixel cells).
REQ-004 The block SHALL have parameter ROWS, 37, text rows (16-line cells).
REQ-005 The block SHALL have parameters H_POL, 1'b1 and V_POL, 1'b1: the active levels of the h_sync_in/h_sync_out and v_sync_in/v_sync_out pairs.
REQ-006 The block SHALL have these ports (name, direction, width, meaning): pixel_clk, in, 1, sole clock; reset, in, 1, synchronous active-high reset.
REQ-007 en, in, 1: high enables the pixel output; low forces blanking.
REQ-008 h_pos, in, 32 and v_pos, in, 32: current beam position from the timing generator.
REQ-009 h_sync_in, in, 1 and v_sync_in, in, 1: syncs aligned with h_pos and v_pos.
REQ-010 char_addr, out, 12: text-buffer read address; char_data, in, 16: {attr[7:0], code[7:0]}, valid one clock after char_addr.
REQ-011 font_addr, out, 12: font read address {code, line[3:0]}; font_data, in, 8: glyph row, MSB = leftmost pixel, valid one clock after font_addr.
REQ-012 cursor_en, in, 1; cursor_col, in, 7; cursor_row, in, 6: cursor control.
REQ-013 rgb, out, 12: {R[3:0], G[3:0], B[3:0]}; h_sync_out, out, 1; v_sync_out, out, 1.

Function
REQ-014 Pipeline edges: E1 registers char_addr; E2 is the RAM read; E3 registers font_addr; E4 is the ROM read; E5 registers rgb.
REQ-015 Latency SHALL be exactly 5 clocks from h_pos, v_pos and syncs to rgb, h_sync_out and v_sync_out.
REQ-016 h_sync_in and v_sync_in SHALL each pass through a 5-stage delay so that they stay aligned with rgb.
REQ-017 Each of the following SHALL travel with its pixel through every stage: pixel column h_pos[2:0], cell line v_pos[3:0], active flag, cursor flag and attribute.
REQ-018 char_addr SHALL be (v_pos>>4)*COLS + (h_pos>>3), truncated to 12 bits.
REQ-019 font_addr SHALL be {char_data[7:0], cell line}.
REQ-020 The active flag SHALL be true only when h_pos < H_PIXELS and v_pos < ROWS*16.
REQ-021 Lines ROWS*16 through V_PIXELS-1 (592-599 by default) SHALL be blank.
REQ-022 The fg and bg colours SHALL come from the attribute: fg = attr[3:0] {I,R,G,B}, bg = attr[6:4] {R,G,B}, blink = attr[7].
REQ-023 Each channel SHALL be: bit set and I set -> 4'hF; bit set only -> 4'hA; bit clear with I set -> 4'h5; otherwise 4'h0. bg uses I = 0.
REQ-024 The pixel SHALL be fg when font_data bit (7 - column) is 1, otherwise bg.
REQ-025 When blink = 1 and frame_cnt[4] = 1, the pixel SHALL be bg regardless of the glyph.
REQ-026 The cursor SHALL be shown when all hold: cursor_en = 1, the cell matches (cursor_col, cursor_row), cell line is 14 or 15, and frame_cnt[3] = 1.
REQ-027 Where the cursor is shown, the pixel SHALL be fg, overriding both the glyph and blink.
REQ-028 The cursor inputs SHALL be sampled at E1 together with the position.
REQ-029 frame_cnt SHALL be a 5-bit counter that increments, wrapping 31 -> 0, on each clock where the sampled h_pos = 0 and v_pos = 0.
REQ-030 frame_cnt SHALL count regardless of en.
REQ-031 rgb SHALL be 12'h000 whenever the delayed active flag is 0, or en was 0 at the pixel's E1 sample.
REQ-032 Positions beyond the text area SHALL never produce a glyph.
REQ-033 The char_addr and font_addr values for them are don't-care but SHALL stay within 12 bits.
REQ-034 There is no stall: one pixel SHALL be accepted every clock.

Reset
REQ-035 While reset = 1 at a clock edge, all pipeline stages SHALL clear: rgb = 0, char_addr = 0, font_addr = 0, frame_cnt = 0, active and cursor flags = 0.
REQ-036 While reset = 1, h_sync_out and every sync delay stage SHALL load ~H_POL; v_sync_out and its delay stages SHALL load ~V_POL.
REQ-037 After reset deasserts, the first 5 outputs SHALL show the cleared stage values (rgb = 0, syncs inactive); valid pixels follow from the 6th clock.
REQ-038 The same clearing SHALL apply if reset is asserted mid-frame.

Verification
REQ-039 Scenario: pos (0,0), char_data 16'h0F41, font_data 8'h80.
- Required: char_addr = 0 after E1.
- Required: font_addr = 12'h410 after E3.
- Required: rgb = 12'hFFF five clocks after the sample.
- Required: the next pixel (h = 1) gives rgb = 12'h000.
REQ-040 Scenario: pos (h = 15, v = 33), attr 8'h1A.
- Required: char_addr = 2*100 + 1 = 201.
- Required: font_addr line = 1.
- Required: a set glyph bit gives rgb = 12'h5F5.
- Required: a clear glyph bit gives rgb = 12'h00A.
REQ-041 Scenario: h_sync_in pulse of 128 clocks.
- Required: h_sync_out shows the same pulse delayed exactly 5 clocks.
- Required: rgb = 0 for h ≥ 800 and for v in 592-599.
REQ-042 Scenario: attr 8'h8F, 32 frames of (0,0) wraps.
- Required: fg shown while frame_cnt[4] = 0.
- Required: bg shown while frame_cnt[4] = 1.
- Required: frame_cnt goes 31 -> 0 on the 32nd wrap.
REQ-043 Scenario: cursor_en = 1 at (5,3), frame_cnt[3] = 1.
- Required: lines 62-63, columns 40-47 show fg even when font_data = 0.
- Required: no cursor pixels when cursor_en = 0.
REQ-044 Scenario: reset asserted mid-line.
- Required: outputs take their reset values on the next edge.
- Required: normal output resumes 5 clocks after release; en = 0 forces rgb = 0 with syncs unaffected.

Source files
------------

// File: rtl/text_mode_renderer_if.sv
// Bus bundle between the text renderer, the timing generator,
// the text-buffer RAM, the font ROM and the video output.
interface text_mode_renderer_if;
    logic        en;
    logic [31:0] h_pos;
    logic [31:0] v_pos;
    logic        h_sync_in;
    logic        v_sync_in;
    logic [11:0] char_addr;
    logic [15:0] char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [11:0] rgb;
    logic        h_sync_out;
    logic        v_sync_out;

    // System side: drives position, memory data and cursor; observes the rest.
    modport master (
        output en, h_pos, v_pos, h_sync_in, v_sync_in,
        output char_data, font_data, cursor_en, cursor_col, cursor_row,
        input  char_addr, font_addr, rgb, h_sync_out, v_sync_out
    );

    // Renderer side.
    modport slave (
        input  en, h_pos, v_pos, h_sync_in, v_sync_in,
        input  char_data, font_data, cursor_en, cursor_col, cursor_row,
        output char_addr, font_addr, rgb, h_sync_out, v_sync_out
    );
endinterface

// File: rtl/text_mode_renderer.sv
// Text-mode renderer: 8x16 character cells, 5-clock fixed pipeline
// (char_addr reg -> RAM read -> font_addr reg -> ROM read -> rgb reg),
// with per-cell attributes, blink and an underline-style cursor.
module text_mode_renderer #(
    parameter int   H_PIXELS = 800,
    parameter int   V_PIXELS = 600,
    parameter int   COLS     = 100,
    parameter int   ROWS     = 37,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1
) (
    input  logic                 pixel_clk,
    input  logic                 reset,
    text_mode_renderer_if.slave  bus
);
    localparam int STAGES     = 5;
    localparam int TEXT_LINES = ROWS * 16;

    // Per-pixel side-band carried alongside the memory reads.
    logic [4:1]      vld_pipe;       // inside the text area
    logic [4:1]      en_pipe;
    logic [4:1]      cur_pipe;       // cursor shown on this pixel
    logic [4:1]      blink_ph_pipe;  // frame_cnt[4] as seen at the E1 sample
    logic [4:1][2:0] col_pipe;       // pixel column within the cell
    logic [2:1][3:0] line_pipe;      // cell line, consumed at E3
    logic [7:0]      attr3, attr4;
    logic [STAGES:1] hs_pipe, vs_pipe;
    logic [4:0]      frame_cnt;
    logic [11:0]     char_addr_q, font_addr_q, rgb_q;

    logic [31:0] cell_col, cell_row, addr_full;
    logic        active_s0, cursor_s0, frame_hit;

    // E1 decode: cell address, active window, cursor hit, frame marker.
    // Blink phase and cursor phase both use frame_cnt before this
    // sample's own increment.
    always_comb begin
        cell_col  = bus.h_pos >> 3;
        cell_row  = bus.v_pos >> 4;
        addr_full = cell_row * 32'(COLS) + cell_col;
        active_s0 = (bus.h_pos < 32'(H_PIXELS)) && (bus.v_pos < 32'(TEXT_LINES))
                    && (bus.v_pos < 32'(V_PIXELS));
        cursor_s0 = bus.cursor_en && frame_cnt[3]
                    && (cell_col == {25'd0, bus.cursor_col})
                    && (cell_row == {26'd0, bus.cursor_row})
                    && (bus.v_pos[3:1] == 3'b111);
        frame_hit = (bus.h_pos == 32'd0) && (bus.v_pos == 32'd0);
    end

    function automatic logic [3:0] chan(input logic b, input logic i);
        if (b) return i ? 4'hF : 4'hA;
        else   return i ? 4'h5 : 4'h0;
    endfunction

    logic [11:0] fg, bg, pix;
    logic        glyph_bit, show_fg;

    // E5 colour select from the glyph row, attribute, blink and cursor.
    always_comb begin
        fg        = {chan(attr4[2], attr4[3]), chan(attr4[1], attr4[3]), chan(attr4[0], attr4[3])};
        bg        = {chan(attr4[6], 1'b0), chan(attr4[5], 1'b0), chan(attr4[4], 1'b0)};
        glyph_bit = bus.font_data[3'd7 - col_pipe[4]];
        show_fg   = cur_pipe[4] | (glyph_bit & ~(attr4[7] & blink_ph_pipe[4]));
        pix       = (vld_pipe[4] && en_pipe[4]) ? (show_fg ? fg : bg) : 12'h000;
    end

    // Pipeline registers, frame counter and sync delay lines.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            char_addr_q   <= '0;
            font_addr_q   <= '0;
            rgb_q         <= '0;
            frame_cnt     <= '0;
            vld_pipe      <= '0;
            en_pipe       <= '0;
            cur_pipe      <= '0;
            blink_ph_pipe <= '0;
            col_pipe      <= '0;
            line_pipe     <= '0;
            attr3         <= '0;
            attr4         <= '0;
            hs_pipe       <= {STAGES{~H_POL}};
            vs_pipe       <= {STAGES{~V_POL}};
        end else begin
            char_addr_q   <= addr_full[11:0];
            vld_pipe      <= {vld_pipe[3:1], active_s0};
            en_pipe       <= {en_pipe[3:1], bus.en};
            cur_pipe      <= {cur_pipe[3:1], cursor_s0};
            blink_ph_pipe <= {blink_ph_pipe[3:1], frame_cnt[4]};
            col_pipe      <= {col_pipe[3:1], bus.h_pos[2:0]};
            line_pipe     <= {line_pipe[1], bus.v_pos[3:0]};
            font_addr_q   <= {bus.char_data[7:0], line_pipe[2]};
            attr3         <= bus.char_data[15:8];
            attr4         <= attr3;
            rgb_q         <= pix;
            hs_pipe       <= {hs_pipe[STAGES-1:1], bus.h_sync_in};
            vs_pipe       <= {vs_pipe[STAGES-1:1], bus.v_sync_in};
            if (frame_hit)
                frame_cnt <= frame_cnt + 5'd1;
        end
    end

    assign bus.char_addr  = char_addr_q;
    assign bus.font_addr  = font_addr_q;
    assign bus.rgb        = rgb_q;
    assign bus.h_sync_out = hs_pipe[STAGES];
    assign bus.v_sync_out = vs_pipe[STAGES];
endmodule

// File: tb/tb_text_mode_renderer.sv
// Directed bench for text_mode_renderer: behavioural RAM/ROM with one
// clock read latency, a vector table of isolated pixels, and hand-written
// sequences for sync delay, blink, cursor and reset.
module tb_text_mode_renderer;
    logic pixel_clk = 1'b0;
    logic reset;
    always #5 pixel_clk = ~pixel_clk;

    text_mode_renderer_if bus();

    text_mode_renderer #(.H_POL(1'b1), .V_POL(1'b0)) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .bus       (bus)
    );

    logic [15:0] ram [0:4095];
    logic [7:0]  rom [0:4095];

    // Synchronous-read memories: data valid one clock after address.
    always @(posedge pixel_clk) begin
        bus.char_data <= ram[bus.char_addr];
        bus.font_data <= rom[bus.font_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] fc = 5'd0;  // reference frame counter

    typedef struct {
        logic [31:0] h, v;
        logic        en, hs, vs;
        logic [11:0] ca, fa, rgb;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] h, input logic [31:0] v, input logic en,
                         input logic cen, input logic hs, input logic vs);
        bus.h_pos = h; bus.v_pos = v; bus.en = en;
        bus.cursor_en = cen; bus.h_sync_in = hs; bus.v_sync_in = vs;
    endtask

    task automatic fill();
        drive(32'd900, 32'd700, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick();
        if (reset) fc = 5'd0;
        else if (bus.h_pos == 32'd0 && bus.v_pos == 32'd0) fc = fc + 5'd1;
        @(posedge pixel_clk);
        #1;
    endtask

    // One pixel followed by off-screen filler; checks addresses at E1/E3
    // (when chk_addr) and rgb/syncs after E5.
    task automatic run_pixel(input string name, input logic [31:0] h, input logic [31:0] v,
                             input logic en, input logic cen, input logic hs, input logic vs,
                             input logic chk_addr, input logic [11:0] ca, input logic [11:0] fa,
                             input logic [11:0] exp_rgb);
        drive(h, v, en, cen, hs, vs);
        tick();
        if (chk_addr) check({name, " char_addr"}, {20'd0, bus.char_addr}, {20'd0, ca});
        fill();
        tick(); tick();
        if (chk_addr) check({name, " font_addr"}, {20'd0, bus.font_addr}, {20'd0, fa});
        tick(); tick();
        check({name, " rgb"}, {20'd0, bus.rgb}, {20'd0, exp_rgb});
        check({name, " h_sync_out"}, {31'd0, bus.h_sync_out}, {31'd0, hs});
        check({name, " v_sync_out"}, {31'd0, bus.v_sync_out}, {31'd0, vs});
    endtask

    logic hs_hist [200];
    logic [31:0] h_hist [200];

    initial begin
        for (int i = 0; i < 4096; i++) begin ram[i] = 16'h0000; rom[i] = 8'h00; end
        ram[0]    = 16'h0F41;  rom[12'h410] = 8'h80;
        ram[201]  = 16'h1A42;  rom[12'h421] = 8'h01;
        ram[2]    = 16'h7000;
        for (int i = 100; i <= 122; i++) ram[i] = 16'h0F00;
        ram[101]  = 16'h0F05;  rom[12'h051] = 8'hFF;
        ram[3699] = 16'h0F00;  ram[3700] = 16'h0F00;  ram[3701] = 16'h0F00;
        for (int i = 0; i < 8; i++) rom[i] = 8'hFF;
        rom[12'h00F] = 8'h01;
        bus.cursor_col = 7'd5;
        bus.cursor_row = 6'd3;

        tbl[0] = '{32'd0,   32'd0,   1'b1, 1'b1, 1'b0, 12'd0,    12'h410, 12'hFFF};
        tbl[1] = '{32'd1,   32'd0,   1'b1, 1'b0, 1'b1, 12'd0,    12'h410, 12'h000};
        tbl[2] = '{32'd15,  32'd33,  1'b1, 1'b1, 1'b1, 12'd201,  12'h421, 12'h5F5};
        tbl[3] = '{32'd14,  32'd33,  1'b1, 1'b0, 1'b0, 12'd201,  12'h421, 12'h00A};
        tbl[4] = '{32'd0,   32'd0,   1'b0, 1'b1, 1'b0, 12'd0,    12'h410, 12'h000};
        tbl[5] = '{32'd800, 32'd0,   1'b1, 1'b0, 1'b1, 12'd100,  12'h000, 12'h000};
        tbl[6] = '{32'd0,   32'd592, 1'b1, 1'b0, 1'b1, 12'd3700, 12'h000, 12'h000};
        tbl[7] = '{32'd799, 32'd591, 1'b1, 1'b1, 1'b0, 12'd3699, 12'h00F, 12'hFFF};
        tbl[8] = '{32'd16,  32'd8,   1'b1, 1'b0, 1'b1, 12'd2,    12'h008, 12'hAAA};
        tbl[9] = '{32'd8,   32'd599, 1'b1, 1'b0, 1'b1, 12'd3701, 12'h007, 12'h000};

        // Reset state.
        reset = 1'b1;
        fill();
        repeat (3) tick();
        check("reset rgb", {20'd0, bus.rgb}, 32'd0);
        check("reset char_addr", {20'd0, bus.char_addr}, 32'd0);
        check("reset font_addr", {20'd0, bus.font_addr}, 32'd0);
        check("reset h_sync_out", {31'd0, bus.h_sync_out}, 32'd0);
        check("reset v_sync_out", {31'd0, bus.v_sync_out}, 32'd1);
        reset = 1'b0;

        // Vector table.
        for (int i = 0; i < 10; i++)
            run_pixel($sformatf("vec%0d", i), tbl[i].h, tbl[i].v, tbl[i].en, 1'b0,
                      tbl[i].hs, tbl[i].vs, 1'b1, tbl[i].ca, tbl[i].fa, tbl[i].rgb);

        // Blank band below the text rows.
        for (int i = 0; i < 8; i++)
            run_pixel($sformatf("vblank%0d", i), 32'(i), 32'(592 + i), 1'b1, 1'b0, 1'b0, 1'b1,
                      1'b1, 12'd3700, 12'(i), 12'h000);

        // 128-clock h_sync pulse streamed through, plus h >= 800 blanking.
        for (int i = 0; i < 200; i++) begin
            hs_hist[i] = (i >= 10 && i < 138);
            h_hist[i]  = 32'(780 + i);
            drive(h_hist[i], 32'd0, 1'b1, 1'b0, hs_hist[i], 1'b1);
            tick();
            if (i >= 4) begin
                check($sformatf("hsync stream %0d", i), {31'd0, bus.h_sync_out}, {31'd0, hs_hist[i-4]});
                if (h_hist[i-4] >= 32'd800)
                    check($sformatf("hblank h=%0d", h_hist[i-4]), {20'd0, bus.rgb}, 32'd0);
            end
        end

        // Cursor with blink phase and cursor phase both on (fc = 24).
        ram[305] = 16'h8F00;
        rom[12'h00E] = 8'hFF;
        rom[12'h00F] = 8'h00;
        drive(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        while (fc != 5'd24) tick();
        for (int v = 62; v <= 63; v++)
            for (int h = 40; h <= 47; h++)
                run_pixel($sformatf("cursor (%0d,%0d)", h, v), 32'(h), 32'(v), 1'b1, 1'b1,
                          1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 12'hFFF);
        run_pixel("cursor line13", 32'd43, 32'd61, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 12'h000);
        run_pixel("cursor col48", 32'd48, 32'd62, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 12'h000);
        run_pixel("cursor off blink", 32'd40, 32'd62, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 12'h000);

        // Cursor phase off (fc = 0).
        drive(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        while (fc != 5'd0) tick();
        run_pixel("cursor phase off", 32'd47, 32'd63, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 12'h000);
        run_pixel("no blink glyph", 32'd40, 32'd62, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 12'hFFF);

        // Blink over 40 frame markers, spanning the 31 -> 0 wrap.
        ram[0] = 16'h8F41;
        for (int i = 0; i < 40; i++) begin
            logic [4:0] fc_at;
            fc_at = fc;
            run_pixel($sformatf("blink fc=%0d", fc_at), 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1,
                      1'b0, 12'd0, 12'd0, fc_at[4] ? 12'h000 : 12'hFFF);
        end

        // Mid-line reset with frame_cnt in its blink-off half.
        drive(32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        while (fc != 5'd16) tick();
        drive(32'd9, 32'd17, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (6) tick();
        check("pre-reset rgb", {20'd0, bus.rgb}, 32'hFFF);
        check("pre-reset char_addr", {20'd0, bus.char_addr}, 32'd101);
        check("pre-reset font_addr", {20'd0, bus.font_addr}, 32'h051);
        check("pre-reset h_sync_out", {31'd0, bus.h_sync_out}, 32'd1);
        reset = 1'b1;
        tick();
        check("midreset rgb", {20'd0, bus.rgb}, 32'd0);
        check("midreset char_addr", {20'd0, bus.char_addr}, 32'd0);
        check("midreset font_addr", {20'd0, bus.font_addr}, 32'd0);
        check("midreset h_sync_out", {31'd0, bus.h_sync_out}, 32'd0);
        check("midreset v_sync_out", {31'd0, bus.v_sync_out}, 32'd1);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("post-reset rgb %0d", k), {20'd0, bus.rgb}, 32'd0);
            check($sformatf("post-reset h_sync %0d", k), {31'd0, bus.h_sync_out}, 32'd0);
            check($sformatf("post-reset v_sync %0d", k), {31'd0, bus.v_sync_out}, 32'd1);
        end
        tick();
        check("resume rgb", {20'd0, bus.rgb}, 32'hFFF);
        check("resume h_sync_out", {31'd0, bus.h_sync_out}, 32'd1);
        check("resume v_sync_out", {31'd0, bus.v_sync_out}, 32'd0);
        drive(32'd9, 32'd17, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        check("en=0 rgb", {20'd0, bus.rgb}, 32'd0);
        check("en=0 h_sync_out", {31'd0, bus.h_sync_out}, 32'd1);
        check("en=0 v_sync_out", {31'd0, bus.v_sync_out}, 32'd0);
        // frame_cnt cleared by reset: blink phase back to visible.
        run_pixel("frame_cnt after reset", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1,
                  1'b0, 12'd0, 12'd0, 12'hFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
